// File: rtl/fifo_rd_modport_pkg.sv
// fifo_rd_pkg: shared widths and types for the read-side FIFO slice
package fifo_rd_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W:0]   ptr_t;
endpackage

// File: rtl/fifo_rd_modport_if.sv
// fifo_rd_modport_if: push/pop handshake and read-side status of the FIFO.
// master drives requests, write data and the almost-empty threshold; slave returns data, flags, count and level.
interface fifo_rd_modport_if #(
  parameter int DATA_W = fifo_rd_pkg::DATA_W,
  parameter int ADDR_W = fifo_rd_pkg::ADDR_W
);
  logic              write_enable;
  logic [DATA_W-1:0] write_data;
  logic              wrfull;
  logic              overflow;
  logic              read_enable;
  logic [ADDR_W-1:0] aempty_value;
  logic [DATA_W-1:0] read_data;
  logic              rdempty;
  logic              rd_almost_empty;
  logic              underflow;
  logic [ADDR_W:0]   fifo_read_count;
  logic [ADDR_W:0]   rd_level;
  modport master (
    output write_enable, write_data, read_enable, aempty_value,
    input  wrfull, overflow, read_data, rdempty, rd_almost_empty, underflow, fifo_read_count, rd_level
  );
  modport slave (
    input  write_enable, write_data, read_enable, aempty_value,
    output wrfull, overflow, read_data, rdempty, rd_almost_empty, underflow, fifo_read_count, rd_level
  );
endinterface

// File: rtl/fifo_rd_modport_mem.sv
// fifo_mem: 2^ADDR_W x DATA_W RAM, synchronous write port and enabled synchronous read port, no reset.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
module fifo_mem #(
  parameter int DATA_W = fifo_rd_pkg::DATA_W,
  parameter int ADDR_W = fifo_rd_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [1<<ADDR_W];
  // Read-before-write: a pop and push to the same slot when full returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_rd_modport.sv
// fifo_rd_modport: single-clock FIFO with registered read-side flags, count and level.
// Ports: rclk clock; hw_rst_n async active-low reset; sw_rst sync active-high reset; bus slave modport.
module fifo_rd_modport
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = fifo_rd_pkg::DATA_W,
  parameter int ADDR_W = fifo_rd_pkg::ADDR_W
) (
  input  logic rclk,
  input  logic hw_rst_n,
  input  logic sw_rst,
  fifo_rd_modport_if.slave bus
);
  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [ADDR_W:0]   wptr, rptr, wnext, rnext, level_next;
  logic              full, empty, push, pop, rd_seen;
  logic [DATA_W-1:0] q;
  // Assert immediately, release two edges after hw_rst_n rises; the release edge still sees reset.
  always_ff @(posedge rclk or negedge hw_rst_n)
    if (!hw_rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  always_comb begin
    full = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    empty = wptr == rptr;
    push = rst_n && !sw_rst && bus.write_enable && (!full || bus.read_enable);
    pop = rst_n && !sw_rst && bus.read_enable && !empty;
    wnext = sw_rst ? '0 : wptr + {{ADDR_W{1'b0}}, push};
    rnext = sw_rst ? '0 : rptr + {{ADDR_W{1'b0}}, pop};
    level_next = wnext - rnext;
  end
  fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk(rclk),
    .we(push),
    .waddr(wptr[ADDR_W-1:0]),
    .wdata(bus.write_data),
    .re(pop),
    .raddr(rptr[ADDR_W-1:0]),
    .rdata(q)
  );
  // The RAM has no reset, so read_data is forced to zero until the first pop after reset.
  assign bus.read_data = rd_seen ? q : '0;
  always_ff @(posedge rclk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      rd_seen <= 1'b0;
      bus.rd_level <= '0;
      bus.rdempty <= 1'b1;
      bus.wrfull <= 1'b0;
      bus.rd_almost_empty <= 1'b1;
      bus.underflow <= 1'b0;
      bus.overflow <= 1'b0;
      bus.fifo_read_count <= '0;
    end else begin
      wptr <= wnext;
      rptr <= rnext;
      rd_seen <= !sw_rst && (rd_seen || pop);
      bus.rd_level <= level_next;
      bus.rdempty <= level_next == '0;
      bus.wrfull <= level_next[ADDR_W];
      bus.rd_almost_empty <= level_next <= {1'b0, bus.aempty_value};
      bus.underflow <= !sw_rst && bus.read_enable && empty;
      bus.overflow <= !sw_rst && bus.write_enable && full && !bus.read_enable;
      bus.fifo_read_count <= sw_rst ? '0 : bus.fifo_read_count + {{ADDR_W{1'b0}}, pop};
    end
endmodule

// File: tb/tb_fifo_rd_modport.sv
// tb_fifo_rd_modport: queue-model scoreboard bench for fifo_rd_modport, driven and sampled on the falling edge.
module tb_fifo_rd_modport;
  import fifo_rd_pkg::*;
  logic rclk = 1'b0;
  logic hw_rst_n = 1'b1;
  logic sw_rst = 1'b0;
  fifo_rd_modport_if bus ();
  fifo_rd_modport dut (.rclk(rclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .bus(bus));
  always #5 rclk = ~rclk;
  data_t mq[$];
  data_t sb[$];
  data_t last;
  int rc;
  int aev;
  logic exp_uf, exp_of;
  int n_pass = 0;
  int n_chk = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic reset_model();
    mq.delete();
    sb.delete();
    last = '0;
    rc = 0;
    exp_uf = 1'b0;
    exp_of = 1'b0;
  endtask
  task automatic check_all();
    check("read_data", bus.read_data, last);
    check("rd_level", 32'(bus.rd_level), 32'(mq.size()));
    check("rdempty", 32'(bus.rdempty), 32'(mq.size() == 0));
    check("wrfull", 32'(bus.wrfull), 32'(mq.size() == 32));
    check("almost_empty", 32'(bus.rd_almost_empty), 32'(mq.size() <= aev));
    check("underflow", 32'(bus.underflow), 32'(exp_uf));
    check("overflow", 32'(bus.overflow), 32'(exp_of));
    check("read_count", 32'(bus.fifo_read_count), 32'(rc));
  endtask
  task automatic step(input logic sw, input logic we, input data_t wd, input logic re);
    logic was_full, was_empty;
    sw_rst = sw;
    bus.write_enable = we;
    bus.write_data = wd;
    bus.read_enable = re;
    bus.aempty_value = 5'(aev);
    was_full = mq.size() == 32;
    was_empty = mq.size() == 0;
    if (sw) reset_model();
    else begin
      exp_uf = re && was_empty;
      exp_of = we && was_full && !re;
      if (re && !was_empty) begin
        sb.push_back(mq.pop_front());
        rc = (rc + 1) % 64;
      end
      if (we && (!was_full || re)) mq.push_back(wd);
    end
    @(posedge rclk);
    @(negedge rclk);
    if (sb.size() != 0) last = sb.pop_front();
    check_all();
    sw_rst = 1'b0;
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b0;
  endtask
  task automatic release_reset();
    @(negedge rclk);
    bus.read_enable = 1'b0;
    bus.write_enable = 1'b1;
    bus.write_data = 32'hDEAD_BEEF;
    hw_rst_n = 1'b1;
    @(negedge rclk);
    @(negedge rclk);
    check("release_push_ignored", 32'(bus.rd_level), 32'd0);
    bus.write_enable = 1'b0;
  endtask
  initial begin
    aev = 4;
    bus.write_enable = 1'b0;
    bus.write_data = '0;
    bus.read_enable = 1'b0;
    bus.aempty_value = 5'd4;
    reset_model();
    #1 hw_rst_n = 1'b0;
    @(negedge rclk);
    @(negedge rclk);
    check_all();
    release_reset();
    step(0, 0, '0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 32'h11 + i, 0);
    for (int i = 0; i < 16; i++) step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    for (int i = 0; i < 32; i++) step(0, 1, $urandom, 0);
    step(0, 1, 32'hBAD0_0001, 0);
    step(0, 0, '0, 0);
    step(0, 1, 32'hCAFE_0001, 1);
    for (int i = 0; i < 32; i++) step(0, 0, '0, 1);
    step(0, 1, 32'h55, 1);
    step(0, 0, '0, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 32'h100 + i, 0);
    step(0, 0, '0, 1);
    step(1, 1, 32'h77, 1);
    step(0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h200 + i, 0);
    aev = 5;
    step(0, 0, '0, 0);
    aev = 4;
    step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    bus.read_enable = 1'b1;
    #2 hw_rst_n = 1'b0;
    #1 reset_model();
    check_all();
    release_reset();
    step(0, 1, 32'h300, 0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
